// File: rtl/seg_scan_if.sv
// Bundle of load-side inputs and display-side outputs for the seven-segment scan block.
interface seg_scan_if;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        lz_blank_en;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  digit_en;
  logic        frame_done;
  logic        update_pending;

  modport master (
    output load, value, dp_mask, lz_blank_en,
    input  seg, seg_dp, digit_en, frame_done, update_pending
  );

  modport slave (
    input  load, value, dp_mask, lz_blank_en,
    output seg, seg_dp, digit_en, frame_done, update_pending
  );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 4-digit seven-segment driver with frame-aligned shadow update,
// inter-digit blanking, per-digit decimal points and leading-zero blanking.
module seg_scan_mux #(
  parameter int SCAN_DIV  = 16000,
  parameter int BLANK_CYC = 64
) (
  input logic      clk,
  input logic      rst_n,
  seg_scan_if.slave bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_t;

  state_t           state_p0, state_nxt;
  logic [CNT_W-1:0] cnt_p0;
  logic [1:0]       dig_p0;
  logic [15:0]      shadow_val, disp_val;
  logic [3:0]       shadow_dp, disp_dp;
  logic             pending;

  logic             wrap, boundary, blank_digit;
  logic [3:0]       digit_nib;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;
  logic [3:0]       en_nxt;

  logic [6:0]       seg_p1;
  logic             dp_p1;
  logic [3:0]       en_p1;
  logic             fd_p1;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h67;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h58;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      4'hF: g = 7'h71;
    endcase
    return g;
  endfunction

  // Stage p0: slot counter, digit index and blank/drive state
  assign wrap     = (cnt_p0 == CNT_MAX);
  assign boundary = wrap && (dig_p0 == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_p0 <= BLANK;
    else        state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt   = state_p0;
    seg_nxt     = 7'd0;
    dp_nxt      = 1'b0;
    en_nxt      = 4'd0;
    digit_nib   = disp_val[{dig_p0, 2'b00} +: 4];
    blank_digit = 1'b0;
    case (dig_p0)
      2'd3:    blank_digit = (disp_val[15:12] == 4'd0);
      2'd2:    blank_digit = (disp_val[15:8]  == 8'd0);
      2'd1:    blank_digit = (disp_val[15:4]  == 12'd0);
      default: blank_digit = 1'b0;
    endcase
    case (state_p0)
      BLANK: if (cnt_p0 == BLANK_LAST) state_nxt = DRIVE;
      DRIVE: begin
        if (wrap) state_nxt = BLANK;
        en_nxt  = 4'b0001 << dig_p0;
        dp_nxt  = disp_dp[dig_p0];
        seg_nxt = (bus.lz_blank_en && blank_digit) ? 7'd0 : glyph(digit_nib);
      end
      default: state_nxt = BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0     <= '0;
      dig_p0     <= 2'd0;
      shadow_val <= 16'd0;
      shadow_dp  <= 4'd0;
      disp_val   <= 16'd0;
      disp_dp    <= 4'd0;
      pending    <= 1'b0;
    end else begin
      cnt_p0 <= wrap ? '0 : cnt_p0 + 1'b1;
      if (wrap) dig_p0 <= dig_p0 + 2'd1;
      if (bus.load) begin
        shadow_val <= bus.value;
        shadow_dp  <= bus.dp_mask;
      end
      // Copy sees the pre-load shadow when a load lands on the boundary cycle
      if (boundary && pending) begin
        disp_val <= shadow_val;
        disp_dp  <= shadow_dp;
      end
      if (bus.load)     pending <= 1'b1;
      else if (boundary) pending <= 1'b0;
    end
  end

  // Stage p1: registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_p1 <= 7'd0;
      dp_p1  <= 1'b0;
      en_p1  <= 4'd0;
      fd_p1  <= 1'b0;
    end else begin
      seg_p1 <= seg_nxt;
      dp_p1  <= dp_nxt;
      en_p1  <= en_nxt;
      fd_p1  <= boundary;
    end
  end

  assign bus.seg            = seg_p1;
  assign bus.seg_dp         = dp_p1;
  assign bus.digit_en       = en_p1;
  assign bus.frame_done     = fd_p1;
  assign bus.update_pending = pending;

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Downstream display stage that drives a 4-digit common-segment seven-segment bank by time multiplexing.
- Accepts a 16-bit hex value through a load strobe and holds it in a shadow register.
- Applies the shadow value only at frame boundaries, so the display never shows a torn value.
- Scans one digit per slot, with a blanking interval between digits to suppress ghosting.
- Provides per-digit decimal points and optional leading-zero blanking.

Parameters:
- SCAN_DIV, 16000: clk cycles per digit slot. Legal range: SCAN_DIV > BLANK_CYC.
- BLANK_CYC, 64: cycles at the start of each slot with all outputs dark. Legal range: BLANK_CYC >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  single-cycle strobe; value and dp_mask are captured into the shadow register
- value  in  16  four hex digits; digit i = value[4i+3:4i], digit 0 is rightmost
- dp_mask  in  4  per-digit decimal-point enable, captured with load
- lz_blank_en  in  1  leading-zero blanking enable, sampled live
- seg  out  7  segments {g,f,e,d,c,b,a}, active high
- seg_dp  out  1  decimal point, active high
- digit_en  out  4  one-hot digit enable, active high
- frame_done  out  1  1-cycle pulse at the end of the digit-3 slot
- update_pending  out  1  shadow holds a value not yet displayed

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. All outputs are registered.
- Reset values:
  - seg=0, seg_dp=0, digit_en=0, frame_done=0, update_pending=0.
  - Shadow and display registers = 0. Digit index = 0. Slot counter = 0. State = BLANK.
- Slot counter: runs 0..SCAN_DIV-1 and wraps. The wrap advances the digit index 0→1→2→3→0.
- State machine (per slot):
  - BLANK while counter < BLANK_CYC.
  - DRIVE while BLANK_CYC <= counter <= SCAN_DIV-1.
  - BLANK→DRIVE when counter = BLANK_CYC-1.
  - DRIVE→BLANK on wrap.
- Output timing:
  - Outputs reflect the state/counter of the previous cycle (1-cycle register latency).
  - After reset release, digit_en=0001 first appears BLANK_CYC+1 cycles later.
- Outputs per state:
  - In BLANK: seg=0, seg_dp=0, digit_en=0.
  - In DRIVE for digit i: digit_en[i]=1, seg=glyph(display digit i), seg_dp=display dp_mask[i].
- Glyph table (lit segments):
  - 0=abcdef, 1=bc, 2=abdeg, 3=abcdg
  - 4=bcfg, 5=acdfg, 6=acdefg, 7=abc
  - 8=abcdefg, 9=abcfg, A=abcefg, b=cdefg
  - c=deg, d=bcdeg, E=adefg, F=aefg
- Leading-zero blanking (lz_blank_en=1):
  - Digit i ∈ {3,2,1} shows seg=0 if digits 3..i of the display value are all 0.
  - Digit 0 is never blanked.
  - digit_en and seg_dp are unaffected by blanking.
- Load handshake:
  - load=1 writes value and dp_mask into the shadow register and sets update_pending=1.
  - Multiple loads before a frame boundary: the last one wins.
  - load is never refused.
- Frame boundary (digit index 3, counter = SCAN_DIV-1):
  - frame_done pulses on the next cycle.
  - If update_pending=1, shadow → display and update_pending clears.
  - The new value is first visible in the digit-0 DRIVE phase of the next frame.
- Load coinciding with the boundary cycle:
  - The copy uses the pre-load shadow contents.
  - The new value is captured into the shadow and update_pending stays 1 until the next boundary.
- Reset mid-scan: everything returns to reset values immediately, with no partial digit drive.
- value and dp_mask are ignored when load=0.

Test Plan:
(Benches use SCAN_DIV=8, BLANK_CYC=2.)
- Reset, then load value=16'h1234 with no further stimulus:
  - Before any load, display is 0000: digit 0 shows seg=0111111 (glyph 0).
  - After the first boundary, digit_en steps 0001,0010,0100,1000 with 2 dark cycles each.
  - Segments for digits 0..3 are 4,3,2,1 (bcfg, abcdg, abdeg, bc).
  - frame_done pulses every 32 cycles.
- Load 16'h00A5 with dp_mask=4'b0100 and lz_blank_en=1:
  - Digits 3 and 2 give seg=0; digit 2 still has seg_dp=1.
  - Digit 1 shows A (abcefg) and digit 0 shows 5 (acdfg).
- Load 16'h0000 with lz_blank_en=1: digits 3..1 are dark, digit 0 shows abcdef.
- Two loads (16'h1111, then 16'h2222) within one frame:
  - The next frame shows only 2222.
  - update_pending goes 1 at the first load and 0 the cycle after the boundary.
- Load 16'hFFFF on the exact boundary cycle while 16'h1111 is pending:
  - The next frame shows 1111.
  - update_pending remains 1.
  - The following frame shows FFFF (aefg on all digits).
- Assert rst_n=0 during the digit-2 DRIVE phase:
  - seg, seg_dp, digit_en and frame_done go 0 asynchronously.
  - After release, the scan restarts at digit 0 with display 0000.
